// File: rtl/multicycle_control_fsm.sv
// Multicycle RV64 integer control unit: sequences fetch/decode/execute/memory/writeback,
// with a bounded memory wait, a retired-instruction counter and sticky trap flags.
module multicycle_control_fsm #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 i_or_d,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           imm_sel,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic                 illegal,
    output logic                 bus_error,
    output logic [3:0]           state
);

    localparam int unsigned WW = $clog2(WAIT_LIMIT + 1);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_LOAD_WB   = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_TRAP      = 4'd11
    } state_t;

    state_t               state_q, state_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [CNT_WIDTH-1:0] retired_count_q, retired_count_d;
    logic                 illegal_q, illegal_d;
    logic                 bus_error_q, bus_error_d;
    logic                 timeout;

    // The last waiting cycle with no ready gives up; ready in that same cycle still completes.
    assign timeout = !mem_ready && (wait_q == WW'(WAIT_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            wait_q          <= '0;
            retired_count_q <= '0;
            illegal_q       <= 1'b0;
            bus_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            retired_count_q <= retired_count_d;
            illegal_q       <= illegal_d;
            bus_error_q     <= bus_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        imm_sel     = 2'b00;
        retire      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    bus_error_d = 1'b1;
                    state_d     = S_TRAP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end

            S_DECODE: begin
                alu_src_b = 2'b10;
                imm_sel   = 2'b10;
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
                    OPC_OP:              state_d = S_EXEC_R;
                    OPC_OP_IMM:          state_d = S_EXEC_I;
                    OPC_BRANCH:          state_d = S_BRANCH;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OPC_STORE) begin
                    imm_sel = 2'b01;
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_MEM_READ;
                end
            end

            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_LOAD_WB;
                end else if (timeout) begin
                    bus_error_d = 1'b1;
                    state_d     = S_TRAP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end

            S_LOAD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout) begin
                    bus_error_d = 1'b1;
                    state_d     = S_TRAP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end

            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end

            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end

            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                case (funct3)
                    3'b000: begin
                        pc_write = zero;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    3'b001: begin
                        pc_write = ~zero;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end

            S_TRAP: state_d = S_TRAP;

            default: state_d = S_IDLE;
        endcase

        retired_count_d = retire ? retired_count_q + CNT_WIDTH'(1) : retired_count_q;
    end

    assign retired_count = retired_count_q;
    assign illegal       = illegal_q;
    assign bus_error     = bus_error_q;
    assign state         = state_q;

endmodule
